// File: rtl/lfsr_checker_if.sv
// Stream and status signals between a PRBS source/monitor and lfsr_checker.
// The master drives the received stream; the slave (checker) reports lock and errors.
interface lfsr_checker_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 enable;
    logic                 data_in;
    logic                 clear_cnt;
    logic                 locked;
    logic                 error;
    logic [CNT_WIDTH-1:0] error_count;

    modport master (
        output enable, data_in, clear_cnt,
        input  locked, error, error_count
    );

    modport slave (
        input  enable, data_in, clear_cnt,
        output locked, error, error_count
    );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising serial PRBS checker for a Fibonacci LFSR stream.
// Fills from the received bits, locks after LOCK_CNT correct predictions, then flywheels.
module lfsr_checker #(
    parameter int unsigned      WIDTH       = 3,
    parameter logic [WIDTH-1:0] TAPS        = 3'b101,
    parameter int unsigned      LOCK_CNT    = 4,
    parameter int unsigned      UNLOCK_ERRS = 3,
    parameter int unsigned      CNT_WIDTH   = 16
) (
    input logic           clk,
    input logic           reset,
    lfsr_checker_if.slave bus
);
    localparam int unsigned FillW  = $clog2(WIDTH + 1);
    localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MissW  = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic {StSearch, StLocked} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     sr_q, sr_d;
    logic [FillW-1:0]     fill_q, fill_d;
    logic [MatchW-1:0]    match_q, match_d;
    logic [MissW-1:0]     miss_q, miss_d;
    logic                 error_q, error_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pred;
    logic                 mismatch;

    assign pred     = ^(sr_q & TAPS);
    assign mismatch = bus.data_in != pred;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        error_d = 1'b0;
        cnt_d   = cnt_q;

        if (bus.enable) begin
            unique case (state_q)
                StSearch: begin
                    sr_d = {sr_q[WIDTH-2:0], bus.data_in};
                    if (fill_q != FillW'(WIDTH)) begin
                        fill_d = fill_q + FillW'(1'b1);
                    end else if (!mismatch && (sr_q != '0)) begin
                        // An all-zero register predicts zeros forever, so it never counts.
                        if (match_q == MatchW'(LOCK_CNT - 1)) begin
                            state_d = StLocked;
                            match_d = '0;
                        end else begin
                            match_d = match_q + MatchW'(1'b1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                StLocked: begin
                    // Flywheel on the prediction so a corrupted bit cannot propagate.
                    sr_d = {sr_q[WIDTH-2:0], pred};
                    if (mismatch) begin
                        error_d = 1'b1;
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1'b1);
                        if (miss_q == MissW'(UNLOCK_ERRS - 1)) begin
                            state_d = StSearch;
                            fill_d  = '0;
                            match_d = '0;
                            miss_d  = '0;
                            sr_d    = {sr_q[WIDTH-2:0], bus.data_in};
                        end else begin
                            miss_d = miss_q + MissW'(1'b1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = StSearch;
            endcase
        end

        if (bus.clear_cnt) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StSearch;
            sr_q    <= '0;
            fill_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.locked      = (state_q == StLocked);
    assign bus.error       = error_q;
    assign bus.error_count = cnt_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker against a queue-based reference model.
// A second instance with a 2-bit counter exercises saturation on the same stimulus.
module tb_lfsr_checker;
    localparam int W = 3;
    localparam int TAPS_I = 5;
    localparam int LOCK = 4;
    localparam int UNLOCK = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    lfsr_checker_if #(.CNT_WIDTH(16)) bus ();
    lfsr_checker_if #(.CNT_WIDTH(2)) bus_s ();

    assign bus_s.enable    = bus.enable;
    assign bus_s.data_in   = bus.data_in;
    assign bus_s.clear_cnt = bus.clear_cnt;

    lfsr_checker #(.WIDTH(3), .TAPS(3'b101), .LOCK_CNT(4), .UNLOCK_ERRS(3), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    lfsr_checker #(.WIDTH(3), .TAPS(3'b101), .LOCK_CNT(4), .UNLOCK_ERRS(3), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    always #5 clk = ~clk;

    // Transmit-side generator and reference model state.
    logic [2:0] g;
    bit m_hist[$];
    bit m_locked, m_err;
    int m_fill, m_match, m_miss, m_cnt16, m_cnt2;

    function automatic bit gen_next();
        bit b = ^(g & 3'b101);
        g = {g[1:0], b};
        return b;
    endfunction

    task automatic model_reset();
        m_hist = {1'b0, 1'b0, 1'b0};
        m_locked = 0; m_err = 0;
        m_fill = 0; m_match = 0; m_miss = 0; m_cnt16 = 0; m_cnt2 = 0;
    endtask

    function automatic bit model_pred();
        bit p = 0;
        for (int k = 0; k < W; k++)
            if (((TAPS_I >> k) & 1) != 0) p ^= m_hist[m_hist.size() - 1 - k];
        return p;
    endfunction

    task automatic model_push(input bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endtask

    task automatic model_step(input bit en, input bit din, input bit clr);
        bit p;
        bit nz;
        m_err = 0;
        if (en) begin
            p = model_pred();
            nz = 0;
            foreach (m_hist[k]) nz |= m_hist[k];
            if (!m_locked) begin
                model_push(din);
                if (m_fill < W) m_fill++;
                else if (din == p && nz) begin
                    m_match++;
                    if (m_match == LOCK) begin m_locked = 1; m_match = 0; end
                end else m_match = 0;
            end else if (din != p) begin
                m_err = 1;
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
                m_miss++;
                if (m_miss == UNLOCK) begin
                    m_locked = 0; m_fill = 0; m_match = 0; m_miss = 0;
                    model_push(din);
                end else model_push(p);
            end else begin
                m_miss = 0;
                model_push(p);
            end
        end
        if (clr) begin m_cnt16 = 0; m_cnt2 = 0; end
    endtask

    function automatic logic [19:0] obs();
        return {bus.locked, bus.error, bus.error_count, bus_s.error_count};
    endfunction

    function automatic logic [19:0] expv();
        return {m_locked, m_err, m_cnt16[15:0], m_cnt2[1:0]};
    endfunction

    task automatic apply(input bit en, input bit din, input bit clr);
        bus.enable = en; bus.data_in = din; bus.clear_cnt = clr;
        @(posedge clk); #1;
        model_step(en, din, clr);
    endtask

    task automatic do_reset();
        bus.enable = 0; bus.data_in = 0; bus.clear_cnt = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.enable = 0; bus.data_in = 0; bus.clear_cnt = 0;
        reset = 1; #2;
        vectors++;
        if (obs() !== 20'h0) begin
            miscompares++; $display("FAIL reset_async: got %h want %h", obs(), 20'h0);
        end
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        vectors++;
        if (obs() !== expv()) begin
            miscompares++; $display("FAIL reset_held: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_clean_lock();
        logic [19:0] want;
        g = 3'b001;  // yields 1,1,0,1,0,0,1,...
        for (int i = 0; i < 50; i++) begin
            apply(1, gen_next(), 0);
            want = {(i >= 6), 1'b0, 16'd0, 2'd0};
            vectors++;
            if (obs() !== want || obs() !== expv()) begin
                miscompares++;
                $display("FAIL clean_lock bit %0d: got %h want %h model %h", i + 1, obs(), want, expv());
            end
        end
    endtask

    task automatic test_single_error();
        apply(1, ~gen_next(), 0);
        vectors++;
        if (obs() !== {1'b1, 1'b1, 16'd1, 2'd1} || obs() !== expv()) begin
            miscompares++; $display("FAIL single_error: got %h model %h", obs(), expv());
        end
        for (int i = 0; i < 20; i++) begin
            apply(1, gen_next(), 0);
            vectors++;
            if (obs() !== {1'b1, 1'b0, 16'd1, 2'd1} || obs() !== expv()) begin
                miscompares++; $display("FAIL single_error_after %0d: got %h model %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_unlock_relock();
        apply(1, gen_next(), 1);
        for (int i = 0; i < 3; i++) begin
            apply(1, ~gen_next(), 0);
            vectors++;
            if (obs() !== {(i < 2), 1'b1, 16'(i + 1), 2'(i + 1)} || obs() !== expv()) begin
                miscompares++; $display("FAIL unlock bit %0d: got %h model %h", i, obs(), expv());
            end
        end
        for (int i = 0; i < 7; i++) begin
            apply(1, gen_next(), 0);
            vectors++;
            if (obs() !== {(i == 6), 1'b0, 16'd3, 2'd3} || obs() !== expv()) begin
                miscompares++; $display("FAIL relock bit %0d: got %h model %h", i + 1, obs(), expv());
            end
        end
    endtask

    task automatic test_zero_stream();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            apply(1, 0, 0);
            vectors++;
            if (obs() !== 20'h0 || obs() !== expv()) begin
                miscompares++; $display("FAIL zero_stream bit %0d: got %h model %h", i, obs(), expv());
            end
        end
        g = 3'b001;
        for (int i = 0; i < 7; i++) begin
            apply(1, gen_next(), 0);
            vectors++;
            if (obs() !== {(i == 6), 1'b0, 16'd0, 2'd0} || obs() !== expv()) begin
                miscompares++; $display("FAIL zero_then_clean bit %0d: got %h model %h", i + 1, obs(), expv());
            end
        end
    endtask

    task automatic test_gaps();
        int valid = 0;
        bit en;
        do_reset();
        g = 3'($urandom_range(1, 7));
        for (int i = 0; i < 200 && valid < 20; i++) begin
            en = ($urandom_range(0, 2) != 0);
            if (en) valid++;
            apply(en, en ? gen_next() : 1'($urandom_range(0, 1)), 0);
            vectors++;
            if (obs() !== {(valid >= 7), 1'b0, 16'd0, 2'd0} || obs() !== expv()) begin
                miscompares++; $display("FAIL gaps valid %0d: got %h model %h", valid, obs(), expv());
            end
        end
    endtask

    task automatic test_clear_priority();
        apply(1, ~gen_next(), 0);
        apply(1, gen_next(), 0);
        vectors++;
        if (bus.error_count !== 16'd1 || obs() !== expv()) begin
            miscompares++; $display("FAIL clear_setup: got %h model %h", obs(), expv());
        end
        apply(1, ~gen_next(), 1);
        vectors++;
        if (obs() !== {1'b1, 1'b1, 16'd0, 2'd0} || obs() !== expv()) begin
            miscompares++; $display("FAIL clear_priority: got %h model %h", obs(), expv());
        end
    endtask

    task automatic test_saturation();
        apply(1, gen_next(), 1);
        for (int k = 0; k < 5; k++) begin
            apply(1, ~gen_next(), 0);
            apply(1, gen_next(), 0);
            apply(1, gen_next(), 0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL saturation err %0d: got %h model %h", k, obs(), expv());
            end
        end
        vectors++;
        if (bus.error_count !== 16'd5 || bus_s.error_count !== 2'd3 || bus.locked !== 1'b1) begin
            miscompares++;
            $display("FAIL saturation_final: got %0d/%0d want 5/3", bus.error_count, bus_s.error_count);
        end
    endtask

    task automatic test_reset_mid();
        apply(1, gen_next(), 1);
        apply(1, ~gen_next(), 0);
        apply(1, gen_next(), 0);
        apply(1, ~gen_next(), 0);
        vectors++;
        if (obs() !== {1'b1, 1'b1, 16'd2, 2'd2} || obs() !== expv()) begin
            miscompares++; $display("FAIL reset_mid_setup: got %h model %h", obs(), expv());
        end
        reset = 1; #1;
        vectors++;
        if (obs() !== 20'h0) begin
            miscompares++; $display("FAIL reset_mid_async: got %h want %h", obs(), 20'h0);
        end
        model_reset();
        bus.enable = 0;
        @(posedge clk); #1;
        reset = 0;
        g = 3'($urandom_range(1, 7));
        for (int i = 0; i < 7; i++) begin
            apply(1, gen_next(), 0);
            vectors++;
            if (obs() !== {(i == 6), 1'b0, 16'd0, 2'd0} || obs() !== expv()) begin
                miscompares++; $display("FAIL reset_relock bit %0d: got %h model %h", i + 1, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        bit en, b, clr;
        do_reset();
        g = 3'($urandom_range(1, 7));
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            b = en ? gen_next() : 1'($urandom_range(0, 1));
            if (en && $urandom_range(0, 7) == 0) b = ~b;
            clr = ($urandom_range(0, 29) == 0);
            apply(en, b, clr);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++; $display("FAIL random cycle %0d: got %h model %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        bus.enable = 0; bus.data_in = 0; bus.clear_cnt = 0;
        test_reset();
        test_clean_lock();
        test_single_error();
        test_unlock_relock();
        test_zero_stream();
        test_gaps();
        test_clear_priority();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Serial PRBS checker that receives the bit stream from the team's Fibonacci LFSR generator. That stream is the feedback bit shifted into the generator's LSB each enabled cycle. The checker self-synchronises its own shift register to the incoming stream and declares lock. Once locked, it free-runs as a flywheel, flags every mismatching bit and counts errors. It sits at the receive end of the LFSR test link, for BIST and link checks.

Parameters:
WIDTH, 3, register length; must match the generator; WIDTH >= 2
TAPS, 3'b101, feedback mask (WIDTH bits); predicted bit = XOR-reduce(sr & TAPS)
LOCK_CNT, 4, consecutive correct predictions needed after fill to declare lock; >= 1
UNLOCK_ERRS, 3, consecutive mismatches while locked that force return to search; >= 1
CNT_WIDTH, 16, width of the saturating error counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
enable  input  1  data_in is a valid stream bit this cycle; when low, all state holds
data_in  input  1  received stream bit (generator's newly inserted LSB)
clear_cnt  input  1  synchronous clear of error_count; acts regardless of enable
locked  output  1  registered; high while in LOCKED state
error  output  1  registered; one-cycle pulse for each mismatching bit while locked
error_count  output  CNT_WIDTH  registered; saturating count of mismatches while locked

Behaviour:
- Reset values:
  - sr = 0, state = SEARCH, fill_cnt = 0, match_cnt = 0, miss_cnt = 0.
  - locked = 0, error = 0, error_count = 0.
- Every enabled cycle computes pred = ^(sr & TAPS).
- When enable = 0: no state change. error is driven to 0 that cycle.
- SEARCH state:
  - Each enabled bit: sr <= {sr[WIDTH-2:0], data_in}.
  - While fill_cnt < WIDTH: fill_cnt increments; no comparison is made.
  - Once filled, compare data_in with pred. Match: match_cnt++. Mismatch: match_cnt <= 0.
  - A bit counts as a match only if sr != 0, so an all-zero stream can never lock.
  - When the LOCK_CNT-th consecutive match is sampled, state <= LOCKED and locked = 1 from that edge.
  - Mismatches in SEARCH do not assert error and do not count.
  - With defaults, locked rises on the edge that samples the 7th valid bit of a clean stream.
- LOCKED state:
  - Each enabled bit: sr <= {sr[WIDTH-2:0], pred}. The flywheel uses the predicted bit, so one corrupted input bit produces exactly one error and does not propagate.
  - Mismatch (data_in != pred): error <= 1 for one cycle; error_count <= error_count + 1, saturating at all-ones; miss_cnt++.
  - Match: miss_cnt <= 0.
  - When the UNLOCK_ERRS-th consecutive mismatch is sampled, that bit is still counted and flagged. On that edge:
    - state <= SEARCH and locked <= 0;
    - fill_cnt, match_cnt and miss_cnt are cleared;
    - sr <= {sr[WIDTH-2:0], data_in}, i.e. the received bit starts a new fill.
- clear_cnt:
  - Sets error_count <= 0 on the next edge.
  - Has priority over a simultaneous increment; the result is 0.
  - Does not affect locked, error or the state machine.
- Reset asserted mid-operation: all outputs drop to their reset values asynchronously. Re-lock needs a full fill plus LOCK_CNT matches.

Test Plan:
1. Reset, then enable = 1 with the clean stream 1,1,0,1,0,0,1 repeated (WIDTH=3, TAPS=101) -> locked = 0 through bit 6, locked = 1 after bit 7; error never asserts; error_count stays 0 over 50 bits.
2. Locked; invert one bit, then a clean stream -> a single error pulse one cycle after that bit; error_count = 1; locked stays 1; no further errors.
3. Locked; invert 3 consecutive bits -> 3 error pulses and error_count = 3; locked = 0 after the 3rd bit. Resume the clean stream -> locked = 1 exactly 7 valid bits later.
4. Reset, then 30 zero bits -> locked stays 0, error stays 0, error_count = 0. Switch to the clean stream -> lock after 7 bits.
5. Clean stream with enable low for random gaps -> lock timing counts valid bits only.
   - clear_cnt asserted together with a mismatch -> error_count = 0.
   - CNT_WIDTH = 2 with 5 isolated errors -> error_count saturates at 3.
6. Locked with error_count = 2; assert reset mid-stream -> locked, error and error_count = 0 immediately, without waiting for a clock edge. Release reset -> re-lock after 7 clean bits.
